// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master engines: state encoding, quarter-phase
// names and protocol constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic I2C_WRITE_BIT = 1'b0;

    localparam logic [1:0] LAST_BYTE_IDX = 2'd2;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-SCL-period tick generator: one-cycle pulse every QUARTER ref_clk
// cycles, restartable from zero through a synchronous clear.
module i2c_quarter_tick #(
    parameter int QUARTER = 125
) (
    input  logic ref_clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    logic [15:0] count;

    assign tick = (count == 16'(QUARTER - 1));

    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/i2c_master_write.sv
// Open-drain I2C master performing one START/addr+W/reg/data/STOP register
// write per accepted request, timed entirely from a quarter-period tick.
module i2c_master_write
    import i2c_pkg::*;
#(
    parameter int QUARTER = 125,
    parameter int ADDR_W  = 7
) (
    input  logic              ref_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] slave_addr,
    input  logic [7:0]        reg_addr,
    input  logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              ack_error,
    output logic              scl_oe,
    output logic              sda_oe,
    input  logic              sda_in
);

    state_t      state, state_n;
    logic [1:0]  phase, phase_n;
    logic [1:0]  byte_idx, byte_idx_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic        ack_error_n;
    logic        busy_n;
    logic        accept;
    logic        tick;
    logic        tick_clear;
    logic        scl_low, sda_low;
    logic [7:0]  byte_buf [3];
    logic [7:0]  cur_byte;

    assign accept     = start && !busy;
    assign tick_clear = (state == ST_IDLE);
    assign cur_byte   = byte_buf[byte_idx];

    i2c_quarter_tick #(
        .QUARTER(QUARTER)
    ) u_tick (
        .ref_clk(ref_clk),
        .reset  (reset),
        .clear  (tick_clear),
        .tick   (tick)
    );

    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            phase     <= Q0;
            byte_idx  <= 2'd0;
            bit_idx   <= 3'd7;
            ack_error <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            byte_idx  <= byte_idx_n;
            bit_idx   <= bit_idx_n;
            ack_error <= ack_error_n;
            busy      <= busy_n;
            done      <= (state == ST_DONE);
            scl_oe    <= scl_low;
            sda_oe    <= sda_low;
        end
    end

    // Request bytes are frozen at accept so the caller may change them freely.
    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                byte_buf[i] <= 8'd0;
            end
        end else if (accept) begin
            byte_buf[0] <= {slave_addr, I2C_WRITE_BIT};
            byte_buf[1] <= reg_addr;
            byte_buf[2] <= wr_data;
        end
    end

    always_comb begin
        state_n     = state;
        phase_n     = phase;
        byte_idx_n  = byte_idx;
        bit_idx_n   = bit_idx;
        ack_error_n = ack_error;
        busy_n      = busy;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n     = ST_START;
                    phase_n     = Q0;
                    ack_error_n = 1'b0;
                    busy_n      = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    phase_n = phase + 2'd1;
                    if (phase == Q3) begin
                        state_n    = ST_BIT;
                        byte_idx_n = 2'd0;
                        bit_idx_n  = 3'd7;
                    end
                end
            end
            ST_BIT: begin
                if (tick) begin
                    phase_n = phase + 2'd1;
                    if (phase == Q3) begin
                        if (bit_idx == 3'd0) begin
                            state_n = ST_ACK;
                        end else begin
                            bit_idx_n = bit_idx - 3'd1;
                        end
                    end
                end
            end
            // The slave's answer is captured at the end of q2 and acted on at the end of q3.
            ST_ACK: begin
                if (tick) begin
                    phase_n = phase + 2'd1;
                    if ((phase == Q2) && sda_in) begin
                        ack_error_n = 1'b1;
                    end
                    if (phase == Q3) begin
                        if (ack_error) begin
                            state_n = ST_STOP;
                        end else if (byte_idx < LAST_BYTE_IDX) begin
                            state_n    = ST_BIT;
                            byte_idx_n = byte_idx + 2'd1;
                            bit_idx_n  = 3'd7;
                        end else begin
                            state_n = ST_STOP;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    phase_n = phase + 2'd1;
                    if (phase == Q3) begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Pad drive levels for the current quarter; registered one cycle later.
    always_comb begin
        scl_low = 1'b0;
        sda_low = 1'b0;
        case (state)
            ST_START: begin
                scl_low = (phase == Q3);
                sda_low = (phase == Q2) || (phase == Q3);
            end
            ST_BIT: begin
                scl_low = (phase == Q0) || (phase == Q1);
                sda_low = !cur_byte[bit_idx];
            end
            ST_ACK: begin
                scl_low = (phase == Q0) || (phase == Q1);
            end
            ST_STOP: begin
                scl_low = (phase == Q0);
                sda_low = (phase == Q0) || (phase == Q1);
            end
            default: begin
                scl_low = 1'b0;
                sda_low = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master_write.sv
// Directed bench for i2c_master_write with QUARTER=2, an open-drain slave
// model and a bus monitor that decodes bytes and times SCL halves.
module tb_i2c_master_write;

    localparam int Q = 2;

    logic       ref_clk;
    logic       reset;
    logic       start;
    logic [6:0] slave_addr;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       ack_error;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_in;

    int vectors     = 0;
    int miscompares = 0;
    int lat;

    // Slave/monitor state: written only by the monitor process.
    logic       slave_pull = 1'b0;
    logic       prev_scl   = 1'b1;
    logic       prev_sda   = 1'b1;
    logic       cur_scl;
    logic       cur_sda;
    logic [7:0] shift_reg  = 8'd0;
    logic [7:0] rx_bytes [3];
    logic       rx_acks  [3];
    int         bit_cnt    = 0;
    int         run_len    = 0;
    int         starts     = 0;
    int         stops      = 0;
    int         bad_halves = 0;
    int         done_cnt   = 0;
    int         seen_epoch = 0;
    int         pos;
    int         idx;

    // Written only by the main stimulus process.
    int nack_byte = -1;
    int mon_epoch = 0;

    assign sda_in = !(sda_oe || slave_pull);

    i2c_master_write #(
        .QUARTER(Q),
        .ADDR_W (7)
    ) dut (
        .ref_clk   (ref_clk),
        .reset     (reset),
        .start     (start),
        .slave_addr(slave_addr),
        .reg_addr  (reg_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .ack_error (ack_error),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .sda_in    (sda_in)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    // Bus monitor and ACKing slave, sampling the wired-AND lines on falling clocks.
    always @(negedge ref_clk) begin
        if (mon_epoch != seen_epoch) begin
            seen_epoch = mon_epoch;
            bit_cnt    = 0;
            run_len    = 0;
            starts     = 0;
            stops      = 0;
            bad_halves = 0;
            done_cnt   = 0;
            slave_pull = 1'b0;
            shift_reg  = 8'd0;
            for (int i = 0; i < 3; i++) begin
                rx_bytes[i] = 8'd0;
                rx_acks[i]  = 1'b1;
            end
            prev_scl = !scl_oe;
            prev_sda = sda_in;
        end else begin
            cur_scl = !scl_oe;
            cur_sda = sda_in;
            run_len++;
            if (done) done_cnt++;
            if (prev_scl && cur_scl && (cur_sda != prev_sda)) begin
                if (!cur_sda) begin
                    starts++;
                    bit_cnt = 0;
                end else begin
                    stops++;
                end
            end
            if (!prev_scl && cur_scl) begin
                if ((bit_cnt > 0) && ((bit_cnt % 9) != 0) && (run_len != 2 * Q)) bad_halves++;
                pos = bit_cnt % 9;
                idx = bit_cnt / 9;
                if (pos < 8) shift_reg = {shift_reg[6:0], cur_sda};
                if ((pos == 7) && (idx < 3)) rx_bytes[idx[1:0]] = shift_reg;
                if ((pos == 8) && (idx < 3)) rx_acks[idx[1:0]] = cur_sda;
                bit_cnt++;
                run_len = 0;
            end else if (prev_scl && !cur_scl) begin
                if ((bit_cnt > 0) && (run_len != 2 * Q)) bad_halves++;
                if ((bit_cnt % 9) == 8) begin
                    slave_pull = (nack_byte != (bit_cnt / 9));
                end else if ((bit_cnt > 0) && ((bit_cnt % 9) == 0)) begin
                    slave_pull = 1'b0;
                end
                run_len = 0;
            end
            prev_scl = cur_scl;
            prev_sda = cur_sda;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitDone(output int latency);
        latency = -1;
        for (int c = 1; c <= 600; c++) begin
            @(posedge ref_clk);
            #1;
            if (done) begin
                latency = c;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input logic [6:0] a, input logic [7:0] r,
                                 input logic [7:0] d, input bit pulse_mid,
                                 input bit hold_start, output int latency);
        @(negedge ref_clk);
        slave_addr = a;
        reg_addr   = r;
        wr_data    = d;
        start      = 1'b1;
        @(posedge ref_clk);
        #1;
        if (!hold_start) start = 1'b0;
        checkOutput("busy_after_accept", busy, 1);
        latency = -1;
        for (int c = 1; c <= 600; c++) begin
            if (pulse_mid && (c == 50)) begin
                start      = 1'b1;
                slave_addr = 7'h55;
                reg_addr   = 8'h00;
                wr_data    = 8'hFF;
            end
            if (pulse_mid && (c == 51)) start = 1'b0;
            @(posedge ref_clk);
            #1;
            if (done) begin
                latency = c;
                break;
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        slave_addr = 7'd0;
        reg_addr   = 8'd0;
        wr_data    = 8'd0;
        repeat (3) @(posedge ref_clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ack_error", ack_error, 0);
        checkOutput("rst_scl_oe", scl_oe, 0);
        checkOutput("rst_sda_oe", sda_oe, 0);
        #2 reset = 1'b1;

        $display("[TB] full write, all bytes ACKed");
        mon_epoch++;
        nack_byte = -1;
        applyStimulus(7'h1A, 8'h0F, 8'hA5, 1'b0, 1'b0, lat);
        checkOutput("s1_latency", lat, 233);
        checkOutput("s1_busy_at_done", busy, 0);
        checkOutput("s1_ack_error", ack_error, 0);
        @(posedge ref_clk);
        #1;
        checkOutput("s1_done_one_cycle", done, 0);
        repeat (6) @(posedge ref_clk);
        #1;
        checkOutput("s1_byte0", rx_bytes[0], 8'h34);
        checkOutput("s1_byte1", rx_bytes[1], 8'h0F);
        checkOutput("s1_byte2", rx_bytes[2], 8'hA5);
        checkOutput("s1_acks", {rx_acks[0], rx_acks[1], rx_acks[2]}, 0);
        checkOutput("s1_starts", starts, 1);
        checkOutput("s1_stops", stops, 1);
        checkOutput("s1_scl_rises", bit_cnt, 28);
        checkOutput("s1_bad_halves", bad_halves, 0);
        checkOutput("s1_done_count", done_cnt, 1);

        $display("[TB] address NACKed");
        mon_epoch++;
        nack_byte = 0;
        applyStimulus(7'h1A, 8'h0F, 8'hA5, 1'b0, 1'b0, lat);
        checkOutput("s2_latency", lat, 89);
        checkOutput("s2_ack_error", ack_error, 1);
        repeat (6) @(posedge ref_clk);
        #1;
        checkOutput("s2_byte0", rx_bytes[0], 8'h34);
        checkOutput("s2_ack0", rx_acks[0], 1);
        checkOutput("s2_scl_rises", bit_cnt, 10);
        checkOutput("s2_stops", stops, 1);
        checkOutput("s2_bad_halves", bad_halves, 0);

        $display("[TB] start pulsed while busy");
        mon_epoch++;
        nack_byte = -1;
        applyStimulus(7'h1A, 8'h0F, 8'hA5, 1'b1, 1'b0, lat);
        checkOutput("s3_latency", lat, 233);
        repeat (20) @(posedge ref_clk);
        #1;
        checkOutput("s3_not_queued", busy, 0);
        checkOutput("s3_done_count", done_cnt, 1);
        checkOutput("s3_byte0", rx_bytes[0], 8'h34);
        checkOutput("s3_byte1", rx_bytes[1], 8'h0F);
        checkOutput("s3_byte2", rx_bytes[2], 8'hA5);
        checkOutput("s3_starts", starts, 1);
        checkOutput("s3_bad_halves", bad_halves, 0);

        $display("[TB] reset asserted mid-byte");
        @(negedge ref_clk);
        slave_addr = 7'h1A;
        reg_addr   = 8'h0F;
        wr_data    = 8'hA5;
        start      = 1'b1;
        @(posedge ref_clk);
        #1;
        start = 1'b0;
        repeat (100) @(posedge ref_clk);
        #1;
        checkOutput("s4_pre_scl_oe", scl_oe, 1);
        checkOutput("s4_pre_sda_oe", sda_oe, 1);
        checkOutput("s4_pre_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("s4_async_scl_oe", scl_oe, 0);
        checkOutput("s4_async_sda_oe", sda_oe, 0);
        checkOutput("s4_async_busy", busy, 0);
        #2 reset = 1'b1;
        repeat (2) @(posedge ref_clk);
        mon_epoch++;
        applyStimulus(7'h1A, 8'h0F, 8'hA5, 1'b0, 1'b0, lat);
        checkOutput("s4_latency", lat, 233);
        checkOutput("s4_ack_error", ack_error, 0);
        repeat (6) @(posedge ref_clk);
        #1;
        checkOutput("s4_byte0", rx_bytes[0], 8'h34);
        checkOutput("s4_byte2", rx_bytes[2], 8'hA5);
        checkOutput("s4_bad_halves", bad_halves, 0);

        $display("[TB] back-to-back with start held");
        mon_epoch++;
        nack_byte = 2;
        applyStimulus(7'h1A, 8'h0F, 8'hA5, 1'b0, 1'b1, lat);
        checkOutput("s5_first_latency", lat, 233);
        checkOutput("s5_first_ack_error", ack_error, 1);
        checkOutput("s5_first_busy", busy, 0);
        nack_byte  = -1;
        slave_addr = 7'h50;
        reg_addr   = 8'h01;
        wr_data    = 8'h3C;
        @(posedge ref_clk);
        #1;
        start = 1'b0;
        checkOutput("s5_second_busy", busy, 1);
        checkOutput("s5_ack_error_cleared", ack_error, 0);
        waitDone(lat);
        checkOutput("s5_second_latency", lat, 233);
        checkOutput("s5_second_ack_error", ack_error, 0);
        repeat (6) @(posedge ref_clk);
        #1;
        checkOutput("s5_byte0", rx_bytes[0], 8'hA0);
        checkOutput("s5_byte1", rx_bytes[1], 8'h01);
        checkOutput("s5_byte2", rx_bytes[2], 8'h3C);
        checkOutput("s5_starts", starts, 2);
        checkOutput("s5_stops", stops, 2);
        checkOutput("s5_done_count", done_cnt, 2);
        checkOutput("s5_bad_halves", bad_halves, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
